ram_arb: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/ram_arb.sv | 118 +++++++++++
 tb/tb_ram_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: response tag and one-hot decode.
// ENABLE/DISABLE match the RAM's OUTREG encoding.
package ram_arb_pkg;

    localparam int DISABLE = 0;
    localparam int ENABLE  = 1;

    // Upper bounds so the tag and decoder can live outside the parameterized module
    localparam int MAX_REQ = 256;
    localparam int MAX_IDW = 8;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } rsp_tag_t;

    function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_REQ-1:0] onehot);
        logic [MAX_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (onehot[i]) idx = idx | MAX_IDW'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [REQ-1:0] grant
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one RAM port among REQ requesters, with tagged read responses.
// Define RAM_ARB_LOCK_EN to add req_lock, letting a requester hold exclusive ownership.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int REQ    = 4,
    parameter int DATA   = 16,
    parameter int DEPTH  = 4,
    parameter int OUTREG = DISABLE,
    parameter int ADDR   = $clog2(DEPTH),
    parameter int IDW    = $clog2(REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REQ-1:0]            req_valid,
    output logic [REQ-1:0]            req_ready,
    input  logic [REQ-1:0]            req_rw_,
    input  logic [REQ-1:0][ADDR-1:0]  req_addr,
    input  logic [REQ-1:0][DATA-1:0]  req_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [REQ-1:0]            req_lock,
`endif
    output logic [REQ-1:0]            rsp_valid,
    output logic [DATA-1:0]           rsp_data,
    output logic                      ram_en,
    output logic                      ram_rw_,
    output logic [ADDR-1:0]           ram_addr,
    output logic [DATA-1:0]           ram_wdata,
    input  logic [DATA-1:0]           ram_rdata
);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gidx;
    logic [REQ-1:0]     eligible;
    logic [REQ-1:0]     grant;
    logic [MAX_REQ-1:0] grant_ext;
    logic               xfer;
    logic               rd_xfer;
    rsp_tag_t           tag;

`ifdef RAM_ARB_LOCK_EN
    logic           owner_vld;
    logic [IDW-1:0] owner;

    // An owner masks everyone else out, even while it has nothing to send
    always_comb begin
        eligible = req_valid & {REQ{~reset}};
        if (owner_vld) eligible = eligible & (REQ'(1) << owner);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_vld <= 1'b0;
            owner     <= '0;
        end else if (xfer) begin
            owner_vld <= req_lock[gidx];
            owner     <= gidx;
        end
    end
`else
    assign eligible = req_valid & {REQ{~reset}};
`endif

    rr_arbiter #(.REQ(REQ), .IDW(IDW)) u_rr (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        grant_ext = '0;
        grant_ext[REQ-1:0] = grant;
    end

    assign gidx      = IDW'(onehot2idx(grant_ext));
    assign xfer      = |grant;
    assign rd_xfer   = xfer & req_rw_[gidx];
    assign req_ready = grant;
    assign ram_en    = xfer;
    assign ram_rw_   = rd_xfer;
    assign ram_addr  = xfer ? req_addr[gidx]  : '0;
    assign ram_wdata = xfer ? req_wdata[gidx] : '0;

    always_ff @(posedge clk) begin
        if (reset)     ptr <= '0;
        else if (xfer) ptr <= (gidx == IDW'(REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
        end else begin
            tag.valid <= rd_xfer;
            tag.id    <= MAX_IDW'(gidx);
        end
    end

    // Gated by reset so a read granted just before reset never answers
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < REQ; i++)
            if (tag.valid && tag.id == MAX_IDW'(i)) rsp_valid[i] = ~reset;
    end

    generate
        if (OUTREG == DISABLE) begin : g_cap
            logic [DATA-1:0] rsp_q;
            always_ff @(posedge clk) begin
                if (reset)        rsp_q <= '0;
                else if (rd_xfer) rsp_q <= ram_rdata;
            end
            assign rsp_data = rsp_q;
        end else begin : g_pass
            assign rsp_data = ram_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: two DUTs (OUTREG disabled / enabled) share stimulus, each on a RAM model.
// Read responses are predicted into a queue and checked by a monitor; RAM_ARB_LOCK_EN adds the lock test.
module tb_ram_arb;
    import ram_arb_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid, req_rw_;
    logic [3:0][1:0] req_addr;
    logic [3:0][15:0] req_wdata;
`ifdef RAM_ARB_LOCK_EN
    logic [3:0]      req_lock;
`endif
    logic [3:0]      ready0, ready1, rsp_valid0, rsp_valid1;
    logic [15:0]     rsp_data0, rsp_data1, wdata0, wdata1, rdata0, rdata1;
    logic            en0, en1, rw0, rw1;
    logic [1:0]      addr0, addr1;
    logic [15:0]     mem0 [4];
    logic [15:0]     mem1 [4];

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    logic [15:0] sh [4];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arb #(.REQ(4), .DATA(16), .DEPTH(4), .OUTREG(DISABLE)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_rw_(req_rw_), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .ram_en(en0), .ram_rw_(rw0),
        .ram_addr(addr0), .ram_wdata(wdata0), .ram_rdata(rdata0)
    );

    ram_arb #(.REQ(4), .DATA(16), .DEPTH(4), .OUTREG(ENABLE)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_rw_(req_rw_), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .ram_en(en1), .ram_rw_(rw1),
        .ram_addr(addr1), .ram_wdata(wdata1), .ram_rdata(rdata1)
    );

    // RAM without output register: asynchronous read
    assign rdata0 = mem0[addr0];
    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 4; i++) mem0[i] <= '0;
        else if (en0 && !rw0) mem0[addr0] <= wdata0;
    end

    // RAM with output register
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem1[i] <= '0;
            rdata1 <= '0;
        end else begin
            if (en1 && !rw1) mem1[addr1] <= wdata1;
            if (en1 && rw1)  rdata1 <= mem1[addr1];
        end
    end

    // Response monitor: exactly the predicted pulse on its due cycle, silence otherwise
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.due != cyc || rsp_valid0 !== e.vld || rsp_valid1 !== e.vld ||
                rsp_data0 !== e.data || rsp_data1 !== e.data)
                $display("FAIL rsp cyc %0d: valid %b/%b data %h/%h, expected valid %b data %h due %0d",
                         cyc, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1, e.vld, e.data, e.due);
            else passes++;
        end else begin
            checks++;
            if (rsp_valid0 !== 4'b0000 || rsp_valid1 !== 4'b0000)
                $display("FAIL rsp_idle cyc %0d: valid %b/%b, expected 0000", cyc, rsp_valid0, rsp_valid1);
            else passes++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bookkeeping for a transfer by requester g (no comparisons here)
    task automatic note_xfer(input int g);
        if (req_rw_[g]) sbq.push_back('{vld: 4'(1 << g), data: sh[req_addr[g]], due: cyc + 1});
        else            sh[req_addr[g]] = req_wdata[g];
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        req_rw_   = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
        req_lock  = '0;
`endif
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0000 || ready1 !== 4'b0000 || en0 !== 1'b0 || en1 !== 1'b0 ||
            rsp_valid0 !== 4'b0000 || rsp_valid1 !== 4'b0000 || rsp_data0 !== 16'h0 || rsp_data1 !== 16'h0)
            $display("FAIL reset_state: ready %b/%b en %b/%b rsp %b/%b data %h/%h, expected all 0",
                     ready0, ready1, en0, en1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1);
        else passes++;
        tick;
    endtask

    task automatic test_write_read;
        do_reset;
        req_valid = 4'b0001; req_rw_ = 4'b0000; req_addr[0] = 2'd2; req_wdata[0] = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0001 || ready1 !== 4'b0001 || en0 !== 1'b1 || en1 !== 1'b1 ||
            rw0 !== 1'b0 || rw1 !== 1'b0 || addr0 !== 2'd2 || addr1 !== 2'd2 ||
            wdata0 !== 16'hBEEF || wdata1 !== 16'hBEEF)
            $display("FAIL wr_port: ready %b/%b en %b/%b rw %b/%b addr %0d/%0d wdata %h/%h, expected 0001 1 0 2 beef",
                     ready0, ready1, en0, en1, rw0, rw1, addr0, addr1, wdata0, wdata1);
        else passes++;
        note_xfer(0);
        tick;
        req_rw_ = 4'b0001;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0001 || ready1 !== 4'b0001 || rw0 !== 1'b1 || rw1 !== 1'b1)
            $display("FAIL rd_port: ready %b/%b rw %b/%b, expected 0001 1", ready0, ready1, rw0, rw1);
        else passes++;
        note_xfer(0);
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0000 || ready1 !== 4'b0000 || en0 !== 1'b0 || en1 !== 1'b0 || rw0 !== 1'b0 ||
            rw1 !== 1'b0 || addr0 !== 2'd0 || addr1 !== 2'd0 || wdata0 !== 16'h0 || wdata1 !== 16'h0)
            $display("FAIL idle_port: ready %b/%b en %b/%b addr %0d/%0d wdata %h/%h, expected all 0",
                     ready0, ready1, en0, en1, addr0, addr1, wdata0, wdata1);
        else passes++;
        tick;
    endtask

    // All four valid: even requesters write the address their odd neighbour reads next cycle
    task automatic test_round_robin;
        logic [3:0] exp;
        do_reset;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                req_rw_[i]   = i[0];
                req_addr[i]  = i[0] ? 2'(i) : 2'(i + 1);
                req_wdata[i] = 16'h5A00 + 16'(i) + 16'((k / 4) * 16);
            end
            exp = 4'(1 << (k % 4));
            @(negedge clk);
            checks++;
            if (ready0 !== exp || ready1 !== exp)
                $display("FAIL rr_grant step %0d: ready %b/%b, expected %b", k, ready0, ready1, exp);
            else passes++;
            note_xfer(k % 4);
            tick;
        end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_sparse;
        int         order [5] = '{1, 3, 1, 3, 0};
        logic [3:0] exp;
        do_reset;
        req_rw_ = 4'b1001; req_addr = '0; req_wdata[1] = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 3) ? 4'b1010 : 4'b1011;
            if (k == 2) req_wdata[1] = 16'h2222;
            exp = 4'(1 << order[k]);
            @(negedge clk);
            checks++;
            if (ready0 !== exp || ready1 !== exp)
                $display("FAIL sparse_grant step %0d: ready %b/%b, expected %b", k, ready0, ready1, exp);
            else passes++;
            note_xfer(order[k]);
            tick;
        end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_raw;
        do_reset;
        req_valid = 4'b0001; req_rw_ = 4'b0000; req_addr[0] = 2'd1; req_wdata[0] = 16'h1234;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0001 || ready1 !== 4'b0001)
            $display("FAIL raw_wr: ready %b/%b, expected 0001", ready0, ready1);
        else passes++;
        note_xfer(0);
        tick;
        req_valid = 4'b0010; req_rw_ = 4'b0010; req_addr[1] = 2'd1;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0010 || ready1 !== 4'b0010)
            $display("FAIL raw_rd: ready %b/%b, expected 0010", ready0, ready1);
        else passes++;
        note_xfer(1);
        tick;
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_back_to_back;
        do_reset;
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            req_rw_[0]   = (k >= 4);
            req_addr[0]  = 2'(k % 4);
            req_wdata[0] = 16'hD000 + 16'((k % 4) * 16'h0111);
            @(negedge clk);
            checks++;
            if (ready0 !== 4'b0001 || ready1 !== 4'b0001)
                $display("FAIL b2b_grant step %0d: ready %b/%b, expected 0001", k, ready0, ready1);
            else passes++;
            note_xfer(0);
            tick;
        end
        req_valid = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_valid = 4'b0100; req_rw_ = 4'b1111; req_addr = '0;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0100 || ready1 !== 4'b0100)
            $display("FAIL midrst_grant: ready %b/%b, expected 0100", ready0, ready1);
        else passes++;
        tick;
        reset = 1'b1; req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (rsp_valid0 !== 4'b0000 || rsp_valid1 !== 4'b0000 || ready0 !== 4'b0000 || ready1 !== 4'b0000)
            $display("FAIL midrst_rsp: rsp %b/%b ready %b/%b, expected 0000",
                     rsp_valid0, rsp_valid1, ready0, ready1);
        else passes++;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0001 || ready1 !== 4'b0001)
            $display("FAIL midrst_ptr: ready %b/%b, expected 0001", ready0, ready1);
        else passes++;
        note_xfer(0);
        tick;
        req_valid = 4'b0000;
        tick;
    endtask

`ifdef RAM_ARB_LOCK_EN
    task automatic test_lock;
        do_reset;
        req_valid = 4'b0010; req_rw_ = 4'b0000; req_addr[1] = 2'd0; req_wdata[1] = 16'h7777;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0010 || ready1 !== 4'b0010)
            $display("FAIL lock_pre: ready %b/%b, expected 0010", ready0, ready1);
        else passes++;
        note_xfer(1);
        tick;
        req_valid = 4'b0101; req_rw_ = 4'b0001; req_addr[0] = 2'd0;
        req_addr[2] = 2'd2; req_wdata[2] = 16'h2222; req_lock = 4'b0100;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0100 || ready1 !== 4'b0100)
            $display("FAIL lock_take: ready %b/%b, expected 0100", ready0, ready1);
        else passes++;
        note_xfer(2);
        tick;
        req_valid = 4'b0001; req_lock = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ready0 !== 4'b0000 || ready1 !== 4'b0000)
                $display("FAIL lock_hold step %0d: ready %b/%b, expected 0000", k, ready0, ready1);
            else passes++;
            tick;
        end
        req_valid = 4'b0101; req_wdata[2] = 16'h3333;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0100 || ready1 !== 4'b0100)
            $display("FAIL lock_release: ready %b/%b, expected 0100", ready0, ready1);
        else passes++;
        note_xfer(2);
        tick;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (ready0 !== 4'b0001 || ready1 !== 4'b0001)
            $display("FAIL lock_after: ready %b/%b, expected 0001", ready0, ready1);
        else passes++;
        note_xfer(0);
        tick;
        req_valid = 4'b0000;
        tick;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_rw_   = 4'b0000;
        req_addr  = '0;
        req_wdata = '1;
`ifdef RAM_ARB_LOCK_EN
        req_lock  = '0;
`endif
        test_reset;
        test_write_read;
        test_round_robin;
        test_sparse;
        test_raw;
        test_back_to_back;
        test_reset_mid;
`ifdef RAM_ARB_LOCK_EN
        test_lock;
`endif
        tick;
        tick;
        checks++;
        if (sbq.size() != 0)
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sbq.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
